issue_queue: RTL

- In-order issue queue directly downstream of the ROB-to-issue pipeline register; it consumes that register's outputs.
- Buffers instructions whose operands are still ROB references and snoops the common data bus (CDB) to wake them up.
- Releases the head entry to the functional-unit select logic once both operands hold data.
- Back-pressures the ROB stage when full.

---
 rtl/issue_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// In-order issue queue: buffers renamed instructions, wakes operands from the CDB,
// and issues only the head entry once both operands hold data.
module issue_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PTR_WIDTH      = 2,
  parameter int unsigned ROB_ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PAYLOAD_WIDTH  = 96
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [ROB_ADDR_WIDTH-1:0] in_rob_addr,
  input  logic                      in_is_ref_1,
  input  logic                      in_is_ref_2,
  input  logic [DATA_WIDTH-1:0]     in_data_1,
  input  logic [DATA_WIDTH-1:0]     in_data_2,
  input  logic [PAYLOAD_WIDTH-1:0]  in_payload,
  output logic                      stall_out,
  input  logic                      cdb_valid,
  input  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_addr,
  input  logic [DATA_WIDTH-1:0]     cdb_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [ROB_ADDR_WIDTH-1:0] out_rob_addr,
  output logic [DATA_WIDTH-1:0]     out_data_1,
  output logic [DATA_WIDTH-1:0]     out_data_2,
  output logic [PAYLOAD_WIDTH-1:0]  out_payload,
  output logic [PTR_WIDTH:0]        count
);

  localparam logic [PTR_WIDTH:0] Full = (PTR_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0]          ref1_q, ref1_d;
  logic [DEPTH-1:0]          ref2_q, ref2_d;
  logic [ROB_ADDR_WIDTH-1:0] rob_q     [DEPTH];
  logic [ROB_ADDR_WIDTH-1:0] rob_d     [DEPTH];
  logic [DATA_WIDTH-1:0]     data1_q   [DEPTH];
  logic [DATA_WIDTH-1:0]     data1_d   [DEPTH];
  logic [DATA_WIDTH-1:0]     data2_q   [DEPTH];
  logic [DATA_WIDTH-1:0]     data2_d   [DEPTH];
  logic [PAYLOAD_WIDTH-1:0]  payload_q [DEPTH];
  logic [PAYLOAD_WIDTH-1:0]  payload_d [DEPTH];
  logic [PTR_WIDTH-1:0]      head_q, head_d;
  logic [PTR_WIDTH-1:0]      tail_q, tail_d;
  logic [PTR_WIDTH:0]        count_q, count_d;

  logic enq, deq;
  logic hit1_in, hit2_in;

  assign stall_out    = (count_q == Full);
  assign count        = count_q;
  assign out_valid    = valid_q[head_q] && !ref1_q[head_q] && !ref2_q[head_q];
  assign out_rob_addr = rob_q[head_q];
  assign out_data_1   = data1_q[head_q];
  assign out_data_2   = data2_q[head_q];
  assign out_payload  = payload_q[head_q];

  assign enq = in_valid && !stall_out && !flush;
  assign deq = out_valid && out_ready;

  // Operands arriving with a tag the CDB is broadcasting right now are captured directly.
  assign hit1_in = in_is_ref_1 && cdb_valid && (in_data_1[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr);
  assign hit2_in = in_is_ref_2 && cdb_valid && (in_data_2[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr);

  always_comb begin
    valid_d   = valid_q;
    ref1_d    = ref1_q;
    ref2_d    = ref2_q;
    rob_d     = rob_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    payload_d = payload_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (ref1_q[i] && (data1_q[i][ROB_ADDR_WIDTH-1:0] == cdb_rob_addr)) begin
          data1_d[i] = cdb_data;
          ref1_d[i]  = 1'b0;
        end
        if (ref2_q[i] && (data2_q[i][ROB_ADDR_WIDTH-1:0] == cdb_rob_addr)) begin
          data2_d[i] = cdb_data;
          ref2_d[i]  = 1'b0;
        end
      end
    end

    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (enq) begin
      valid_d[tail_q]   = 1'b1;
      rob_d[tail_q]     = in_rob_addr;
      ref1_d[tail_q]    = in_is_ref_1 && !hit1_in;
      ref2_d[tail_q]    = in_is_ref_2 && !hit2_in;
      data1_d[tail_q]   = hit1_in ? cdb_data : in_data_1;
      data2_d[tail_q]   = hit2_in ? cdb_data : in_data_2;
      payload_d[tail_q] = in_payload;
      tail_d            = tail_q + 1'b1;
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ref1_q  <= '0;
      ref2_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i]     <= '0;
        data1_q[i]   <= '0;
        data2_q[i]   <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      ref1_q    <= ref1_d;
      ref2_q    <= ref2_d;
      rob_q     <= rob_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      payload_q <= payload_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule
